// File: rtl/nic_channel_ctrl.sv
// nic_channel_ctrl: network interface between one processor and its router port.
// Holds a single-entry input channel buffer (router -> processor) and a
// single-entry output channel buffer (processor -> router), each tracked by a
// two-state EMPTY/FULL machine whose state is the channel's status flag.
// Packet bits are numbered [0:DATA_WIDTH-1] with bit 0 the MSB, so VC_BIT is
// translated to a little-endian storage index below.
module nic_channel_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:1]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    localparam int VC_IDX = DATA_WIDTH - 1 - VC_BIT;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } chan_state_t;

    chan_state_t           in_state;
    chan_state_t           in_next;
    chan_state_t           out_state;
    chan_state_t           out_next;
    logic [DATA_WIDTH-1:0] icb;
    logic [DATA_WIDTH-1:0] ocb;
    logic                  ics;
    logic                  ocs;
    logic                  capture;
    logic                  drain;
    logic                  load;

    assign ics = (in_state == CH_FULL);
    assign ocs = (out_state == CH_FULL);

    // Handshake decode, load-data mux and next-state logic for both channels
    always_comb begin
        in_next  = in_state;
        out_next = out_state;
        net_ri   = 1'b0;
        net_so   = 1'b0;
        d_out    = '0;
        net_do   = '0;
        capture  = 1'b0;
        drain    = 1'b0;
        load     = 1'b0;

        if (reset) begin
            net_ri  = !ics;
            net_so  = ocs && net_ro && (ocb[VC_IDX] == net_polarity);
            net_do  = ocb;
            capture = net_si && net_ri;
            drain   = nicEn && !nicWrEn && (addr == 2'b00) && ics;
            load    = nicEn && nicWrEn && (addr == 2'b10) && !ocs;

            if (nicEn && !nicWrEn) begin
                case (addr)
                    2'b00:   d_out = icb;
                    2'b01:   d_out = {{(DATA_WIDTH-1){1'b0}}, ics};
                    2'b11:   d_out = {{(DATA_WIDTH-1){1'b0}}, ocs};
                    default: d_out = '0;
                endcase
            end
        end

        if (capture) begin
            in_next = CH_FULL;
        end else if (drain) begin
            in_next = CH_EMPTY;
        end

        if (net_so) begin
            out_next = CH_EMPTY;
        end else if (load) begin
            out_next = CH_FULL;
        end
    end

    // Channel state and buffer registers; reset discards any buffered packets
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state  <= CH_EMPTY;
            out_state <= CH_EMPTY;
            icb       <= '0;
            ocb       <= '0;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
            if (capture) begin
                icb <= net_di;
            end
            if (load) begin
                ocb <= d_in;
            end
        end
    end

endmodule
